// File: rtl/collatz_range_if.sv
// Purpose: handshake/read bundle between the lab1 controller and the collatz_range engine.
// Latency: n/a (wiring only).
// Backpressure: none; go is a pulse that the engine ignores while busy.
// Ports: go/start (start request and range base), rd_addr/count (result read port),
//        done/busy (run status). master = controller side, slave = engine side.
interface collatz_range_if #(
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_WIDTH   = 16
);
    logic                     go;
    logic [31:0]              start;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic                     done;
    logic                     busy;
    logic [COUNT_WIDTH-1:0]   count;

    modport master (
        output go, start, rd_addr,
        input  done, busy, count
    );

    modport slave (
        input  go, start, rd_addr,
        output done, busy, count
    );
endinterface

// File: rtl/collatz_range.sv
// Purpose: computes Collatz iteration counts for RAM_WORDS consecutive start values into a RAM.
// Latency: steps+2 cycles per value, done one cycle after the last write; read port 1 cycle.
// Backpressure: go is ignored while busy; a new go is accepted in IDLE the cycle after done.
// Ports: clk, reset (async, active-high); bus.slave carries go/start in, done/busy out,
//        and the registered read port rd_addr -> count.
module collatz_range #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input logic            clk,
    input logic            reset,
    collatz_range_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_INDEX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [31:0]              base;
    logic [31:0]              n;
    logic [COUNT_WIDTH-1:0]   steps;
    logic [RAM_ADDR_BITS-1:0] index;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic                     busy_c;
    logic                     done_c;

    logic [COUNT_WIDTH-1:0]   mem [RAM_WORDS];

    // 0 and 1 both end the walk; 0 would otherwise loop forever on the even branch.
    logic        n_term;
    logic        last_word;
    logic [31:0] n_odd_next;

    assign n_term     = (n == 32'd0) || (n == 32'd1);
    assign last_word  = (index == LAST_INDEX);
    // 3n+1 truncated to 32 bits; overflow wraps silently.
    assign n_odd_next = (n << 1) + n + 32'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.go) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ITER;
            S_ITER:  if (n_term) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_c = (state != S_IDLE);
        done_c = (state == S_DONE);
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.count = count_q;

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base  <= '0;
            n     <= '0;
            steps <= '0;
            index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        base  <= bus.start;
                        index <= '0;
                    end
                end
                S_LOAD: begin
                    n     <= base;
                    steps <= COUNT_WIDTH'(1);
                end
                S_ITER: begin
                    if (!n_term) begin
                        n <= n[0] ? n_odd_next : (n >> 1);
                        // Saturate rather than wrap so a huge count never reads as small.
                        if (steps != '1) begin
                            steps <= steps + COUNT_WIDTH'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        index <= index + RAM_ADDR_BITS'(1);
                        base  <= base + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result RAM: one write port, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (state == S_WRITE) begin
            mem[index] <= (n == 32'd0) ? '0 : steps;
        end
    end

    // Registered read; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= mem[bus.rd_addr];
        end
    end

endmodule

// File: tb/tb_collatz_range.sv
// Purpose: self-checking bench for collatz_range with an 8-word RAM.
// Latency: checks done timing against a per-value cost of steps+2 cycles.
// Backpressure: exercises go held high while busy and back-to-back runs.
module tb_collatz_range;

    localparam int WORDS = 8;
    localparam int AB    = 3;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #10 clk = ~clk;

    collatz_range_if #(.RAM_ADDR_BITS(AB), .COUNT_WIDTH(CW)) bus ();

    collatz_range #(
        .RAM_WORDS    (WORDS),
        .RAM_ADDR_BITS(AB),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [CW-1:0] sb_q [$];
    logic [CW-1:0] old_mem [WORDS];
    logic [CW-1:0] new_mem [WORDS];

    typedef struct {
        logic [31:0]   start;
        logic [AB-1:0] addr;
        logic [CW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs [12];

    // Number of ITER-visible steps: value 1 counts 1, each update adds 1; 0 stops at once.
    function automatic int model_steps(input logic [31:0] v);
        int c;
        logic [31:0] x;
        x = v;
        c = 1;
        while (x != 32'd1 && x != 32'd0 && c < 200000) begin
            x = x[0] ? (32'd3 * x + 32'd1) : (x >> 1);
            c++;
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] model_store(input logic [31:0] v);
        int c;
        if (v == 32'd0) return '0;
        c = model_steps(v);
        return (c > 65535) ? 16'hFFFF : CW'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [AB-1:0] addr, input logic [CW-1:0] exp, input string name);
        bus.rd_addr = addr;
        sb_q.push_back(exp);
        tick();
        check(name, 32'(bus.count), 32'(sb_q.pop_front()));
    endtask

    task automatic apply_vecs(input logic [31:0] s);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].start == s) read_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
    endtask

    // One full run. sweep: read the RAM every cycle (alternating the word being
    // processed and a random word) and expect old data until its write edge has passed.
    // hammer: keep go high while busy.
    task automatic run_range(input logic [31:0] s, input bit sweep, input bit hammer, input string tag);
        int wr_edge [WORDS];
        int cum;
        int t;
        int done_at;
        int n_done;
        bit fin;
        cum = 0;
        for (int k = 0; k < WORDS; k++) begin
            new_mem[k] = model_store(s + 32'(k));
            cum += model_steps(s + 32'(k)) + 2;
            wr_edge[k] = cum;
        end
        bus.start = s;
        bus.go    = 1'b1;
        tick();
        if (!hammer) bus.go = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        n_done  = 0;
        done_at = -1;
        t       = 0;
        fin     = 1'b0;
        while (!fin && t < 4000) begin
            if (sweep) begin
                int a;
                if ((t % 2) == 0) begin
                    a = 0;
                    while (a < WORDS - 1 && wr_edge[a] < t + 1) a++;
                end else begin
                    a = $urandom_range(0, WORDS - 1);
                end
                bus.rd_addr = AB'(a);
                sb_q.push_back((wr_edge[a] < t + 1) ? new_mem[a] : old_mem[a]);
            end
            tick();
            t++;
            if (sweep) check({tag, "_sweep"}, 32'(bus.count), 32'(sb_q.pop_front()));
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = t;
                bus.go = 1'b0;
            end
            if (done_at >= 0 && t == done_at + 1) fin = 1'b1;
        end
        bus.go = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_at), 32'(cum));
        check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        for (int k = 0; k < WORDS; k++) old_mem[k] = new_mem[k];
    endtask

    initial begin
        vecs[0]  = '{32'd1,  3'd0, 16'd1,   "s1_r0"};
        vecs[1]  = '{32'd1,  3'd1, 16'd2,   "s1_r1"};
        vecs[2]  = '{32'd1,  3'd2, 16'd8,   "s1_r2"};
        vecs[3]  = '{32'd1,  3'd3, 16'd3,   "s1_r3"};
        vecs[4]  = '{32'd27, 3'd0, 16'd112, "s27_r0"};
        vecs[5]  = '{32'd27, 3'd4, 16'd107, "s27_r4"};
        vecs[6]  = '{32'd27, 3'd7, 16'd14,  "s27_r7"};
        vecs[7]  = '{32'd5,  3'd0, 16'd6,   "s5_r0"};
        vecs[8]  = '{32'd5,  3'd2, 16'd17,  "s5_r2"};
        vecs[9]  = '{32'd0,  3'd0, 16'd0,   "s0_r0"};
        vecs[10] = '{32'd0,  3'd1, 16'd1,   "s0_r1"};
        vecs[11] = '{32'd0,  3'd2, 16'd2,   "s0_r2"};

        bus.go      = 1'b0;
        bus.start   = '0;
        bus.rd_addr = '0;
        #5 reset = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        reset = 1'b0;
        tick();

        run_range(32'd1, 1'b0, 1'b0, "run1");
        apply_vecs(32'd1);

        // Sweep run overwrites the start=1 contents, then a back-to-back hammered run.
        run_range(32'd27, 1'b1, 1'b0, "run27");
        run_range(32'd27, 1'b0, 1'b1, "hammer");
        apply_vecs(32'd27);
        for (int k = 0; k < WORDS; k++) read_chk(AB'(k), new_mem[k], "hammer_rd");

        // Reset in the middle of a run.
        bus.start = 32'd27;
        bus.go    = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_count", 32'(bus.count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_idle", 32'(bus.busy), 32'd0);

        run_range(32'd5, 1'b0, 1'b0, "run5");
        apply_vecs(32'd5);

        run_range(32'd0, 1'b0, 1'b0, "run0");
        apply_vecs(32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collatz_range.md
Name: collatz_range

Overview:
Iteration engine fed by the lab1 top-level controller. It takes a debounced one-cycle `go` pulse and a 32-bit starting value. It computes Collatz iteration counts for RAM_WORDS consecutive values (start, start+1, …) and stores each count in an internal RAM. It pulses `done` when all values are finished, then serves counts through a registered read port that drives the top level's hex display.

Parameters:
RAM_WORDS, 256, number of consecutive start values evaluated and stored
RAM_ADDR_BITS, 8, width of RAM index and rd_addr; must satisfy 2**RAM_ADDR_BITS >= RAM_WORDS
COUNT_WIDTH, 16, width of stored iteration counts

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
go  input  1  one-cycle start request; sampled only in IDLE
start  input  32  first value of the range; latched when go is accepted
rd_addr  input  RAM_ADDR_BITS  RAM read index (offset from latched start)
done  output  1  one-cycle pulse when all RAM_WORDS results are written
busy  output  1  high from go acceptance until the cycle done is asserted (inclusive)
count  output  COUNT_WIDTH  RAM[rd_addr], registered, 1-cycle read latency

Behaviour:
- Clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: done=0, busy=0, count=0, state=IDLE, index=0. RAM contents are not cleared.
- Internal registers: base[31:0], n[31:0], steps[COUNT_WIDTH-1:0], index[RAM_ADDR_BITS-1:0].
- State machine:
  - IDLE: if go=1, latch base<=start, index<=0, go to LOAD. Otherwise stay.
  - LOAD: n<=base, steps<=1, go to ITER.
  - ITER:
    - If n==1 or n==0, go to WRITE.
    - Else if n even, n<=n>>1.
    - Else n<=3n+1, truncated to 32 bits (wrap on overflow, no error flag).
    - On each update, steps<=steps+1, saturating at all-ones.
  - WRITE:
    - RAM[index]<=steps, or 0 if n==0.
    - If index==RAM_WORDS-1, go to DONE.
    - Else index<=index+1, base<=base+1 (32-bit wrap), go to LOAD.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Count convention: value 1 yields 1; each iteration adds 1 (3 yields 8).
- Start value 0 terminates immediately and stores 0; this avoids an infinite loop.
- Per-value cost: steps+2 cycles (LOAD, steps ITER cycles, WRITE); done follows one cycle after the final WRITE.
- `busy` is combinationally high whenever state != IDLE.
- go while busy is ignored; a new go is accepted in IDLE the cycle after done.
- Read port:
  - count<=RAM[rd_addr] every clock, independent of state.
  - A read of the same address being written in WRITE returns the old data.
  - rd_addr >= RAM_WORDS returns undefined data.
- Reset mid-operation: immediate return to IDLE, no done pulse; partially written RAM retains values.
- RAM is inferred as a single-write, single-registered-read block RAM.

Test Plan:
- Reset, RAM_WORDS=4, start=1, go pulse -> busy rises next cycle. done pulses once, 22 clocks after the go-sampling edge. rd_addr 0..3 read back 1, 2, 8, 3 with 1-cycle latency.
- start=27, go -> RAM[0]=112. RAM[4] (value 31)=107. RAM[7] (value 34)=14.
- go re-pulsed every cycle while busy -> ignored. Exactly one done pulse, results identical to a single-go run.
- Assert reset mid-run (after about 10 cycles) -> busy=0, done=0, count=0 immediately. A following go with start=5 yields RAM[0]=6, RAM[2]=17 (value 7).
- start=0 -> RAM[0]=0, RAM[1]=1, RAM[2]=2. Run completes and done pulses.
- Sweep rd_addr during a run, including the address currently being written -> count matches the RAM model with old-data-on-collision. done asserted exactly once per accepted go.
